// File: rtl/d_ram_bank_if.sv
// ----------------------------------------------------------------------------
// d_ram_bank_if
// Request/response bundle between a requester (load/store unit or bus
// adapter) and a d_ram_bank.
//
//   req_valid/req_ready : request handshake (requester -> bank)
//   req_we              : 1 = write, 0 = read
//   req_addr            : word address
//   req_wstrb           : byte write enables, bit i covers data[8i+7:8i]
//   req_wdata           : write data
//   rsp_valid/rsp_ready : read-response handshake (bank -> requester)
//   rsp_rdata           : read data
//   rsp_err             : read address was beyond the populated depth
//
// master modport: requester side.  slave modport: bank side.
// ----------------------------------------------------------------------------
interface d_ram_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W/8-1:0]   req_wstrb;
  logic [DATA_W-1:0]     req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wstrb, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wstrb, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/d_ram_bank.sv
// ----------------------------------------------------------------------------
// d_ram_bank
// Single-port data RAM bank with byte-strobe writes, a read latency of 1 or 2
// cycles and a credit-protected response FIFO so the requester can stall
// responses without data loss.
//
// Parameters:
//   DATA_W : data width (multiple of 8)
//   ADDR_W : word-address width
//   DEPTH  : populated words (<= 2**ADDR_W); higher addresses are out of range
//   RD_LAT : read latency, 1 or 2
//
// Ports:
//   clk    : clock, all state updates on the rising edge
//   resetn : asynchronous active-low reset (memory contents are kept)
//   bus    : d_ram_bank_if slave modport (request + response channels)
// ----------------------------------------------------------------------------
module d_ram_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          resetn,
  d_ram_bank_if.slave   bus
);

  localparam int NBYTES = DATA_W / 8;
  localparam int FIFO_D = RD_LAT + 1;
  localparam int PTR_W  = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CNT_W  = $clog2(FIFO_D + 1);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_W:0]    DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]   CREDITS  = CNT_W'(FIFO_D);
  localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(FIFO_D - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_cnt;     // reads accepted but not yet popped
  logic [CNT_W-1:0]  r_fill;    // response FIFO occupancy
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic              w_req_ready;
  logic              w_accept;
  logic              w_wr_fire;
  logic              w_rd_fire;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rd_word;

  // Ready is a pure function of the credit register, so there is no
  // combinational path from any request or response input.
  assign w_req_ready = (r_cnt < CREDITS);
  assign w_accept    = bus.req_valid & w_req_ready;
  assign w_wr_fire   = w_accept & bus.req_we;
  assign w_rd_fire   = w_accept & ~bus.req_we;
  assign w_in_range  = ({1'b0, bus.req_addr} < DEPTH_L);
  assign w_idx       = bus.req_addr[IDX_W-1:0];

  // Out-of-range reads return zero; the index is only meaningful in range.
  assign w_rd_word   = w_in_range ? r_mem[w_idx] : '0;

  // --------------------------------------------------------------------------
  // Memory array: byte-granular write, never reset
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_wr_fire && w_in_range) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (bus.req_wstrb[i]) begin
          r_mem[w_idx][i*8 +: 8] <= bus.req_wdata[i*8 +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read pipeline: RD_LAT-1 extra stages between the array sample and the FIFO
  // --------------------------------------------------------------------------
  logic              w_push;
  logic [DATA_W-1:0] w_push_data;
  logic              w_push_err;

  generate
    if (RD_LAT >= 2) begin : g_pipe
      logic              r_pipe_valid;
      logic [DATA_W-1:0] r_pipe_data;
      logic              r_pipe_err;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_pipe_valid <= 1'b0;
        end else begin
          r_pipe_valid <= w_rd_fire;
        end
      end

      always_ff @(posedge clk) begin
        if (w_rd_fire) begin
          r_pipe_data <= w_rd_word;
          r_pipe_err  <= ~w_in_range;
        end
      end

      assign w_push      = r_pipe_valid;
      assign w_push_data = r_pipe_data;
      assign w_push_err  = r_pipe_err;
    end else begin : g_direct
      // Latency 1: the FIFO slot itself is the registered read output.
      assign w_push      = w_rd_fire;
      assign w_push_data = w_rd_word;
      assign w_push_err  = ~w_in_range;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Response FIFO storage (one register slot per entry)
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_slot_data [FIFO_D];
  logic              w_slot_err  [FIFO_D];

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_D; gi++) begin : g_slot
      logic [DATA_W-1:0] r_data;
      logic              r_err;

      always_ff @(posedge clk) begin
        if (w_push && (r_wptr == PTR_W'(gi))) begin
          r_data <= w_push_data;
          r_err  <= w_push_err;
        end
      end

      assign w_slot_data[gi] = r_data;
      assign w_slot_err[gi]  = r_err;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FIFO pointers, occupancy and credit counter
  // --------------------------------------------------------------------------
  logic w_rsp_valid;
  logic w_pop;

  assign w_rsp_valid = (r_fill != '0);
  assign w_pop       = w_rsp_valid & bus.rsp_ready;

  // FIFO depth may be 3, so pointers wrap explicitly rather than by overflow.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end

      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase

      // Credits cover the whole in-flight path (pipeline + FIFO), which is
      // what guarantees the FIFO never overflows.
      case ({w_rd_fire, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: data/err are forced to zero while empty so the reset values
  // appear immediately, without resetting the data slots.
  // --------------------------------------------------------------------------
  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_rdata = w_rsp_valid ? w_slot_data[r_rptr] : '0;
  assign bus.rsp_err   = w_rsp_valid ? w_slot_err[r_rptr]  : 1'b0;

endmodule

// File: tb/tb_d_ram_bank.sv
// ----------------------------------------------------------------------------
// tb_d_ram_bank
// Two banks: dut1 (RD_LAT=1, DEPTH=3000) and dut2 (RD_LAT=2, DEPTH=4096).
// Stimulus pushes expected read responses into per-bank queues; independent
// monitors pop and compare whenever a response is handed over.
// ----------------------------------------------------------------------------
module tb_d_ram_bank;

  logic clk    = 1'b0;
  logic resetn = 1'b1;

  int checks   = 0;
  int failures = 0;
  int pops1    = 0;
  int pops2    = 0;

  logic [32:0] q1 [$];
  logic [32:0] q2 [$];

  d_ram_bank_if #(.DATA_W(32), .ADDR_W(12)) if1 ();
  d_ram_bank_if #(.DATA_W(32), .ADDR_W(12)) if2 ();

  d_ram_bank #(.DATA_W(32), .ADDR_W(12), .DEPTH(3000), .RD_LAT(1)) dut1 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (if1.slave)
  );

  d_ram_bank #(.DATA_W(32), .ADDR_W(12), .DEPTH(4096), .RD_LAT(2)) dut2 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (if2.slave)
  );

  initial begin
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end else begin
      $display("ok   %s value=0x%0h", name, act);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic we,
                       input logic [11:0] a, input logic [3:0] s, input logic [31:0] d);
    if (sel == 1) begin
      if1.req_valid = v; if1.req_we = we; if1.req_addr = a;
      if1.req_wstrb = s; if1.req_wdata = d;
    end else begin
      if2.req_valid = v; if2.req_we = we; if2.req_addr = a;
      if2.req_wstrb = s; if2.req_wdata = d;
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 1) ? if1.req_ready : if2.req_ready;
  endfunction

  task automatic push_exp(input int sel, input logic [32:0] e);
    if (sel == 1) q1.push_back(e);
    else          q2.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input int sel, input logic we, input logic [11:0] a,
                       input logic [3:0] s, input logic [31:0] d,
                       input logic [31:0] exp_d, input logic exp_e, output int waits);
    logic acc;
    acc   = 1'b0;
    waits = 0;
    drive(sel, 1'b1, we, a, s, d);
    while (!acc && waits < 64) begin
      @(negedge clk);
      acc = get_ready(sel);
      if (!acc) waits++;
      @(posedge clk);
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout dut%0d addr=%0d actual=not_accepted required=accepted", sel, a);
    end else if (!we) begin
      push_exp(sel, {exp_e, exp_d});
    end
    $display("req  dut%0d %s addr=%0d strb=0x%0h wdata=0x%0h waits=%0d",
             sel, we ? "WR" : "RD", a, s, d, waits);
    #1;
    drive(sel, 1'b0, 1'b0, 12'd0, 4'd0, 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_outstanding", 64'(q1.size() + q2.size()), 64'd0);
  endtask

  // --------------------------------------------------------------------------
  // Monitors
  // --------------------------------------------------------------------------
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (resetn && if1.rsp_valid && if1.rsp_ready) begin
        pops1++;
        if (q1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp1_unexpected actual=0x%0h required=no_response", if1.rsp_rdata);
        end else begin
          e = q1.pop_front();
          chk("rsp1", {31'd0, if1.rsp_err, if1.rsp_rdata}, {31'd0, e});
        end
      end
    end
  end

  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (resetn && if2.rsp_valid && if2.rsp_ready) begin
        pops2++;
        if (q2.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp2_unexpected actual=0x%0h required=no_response", if2.rsp_rdata);
        end else begin
          e = q2.pop_front();
          chk("rsp2", {31'd0, if2.rsp_err, if2.rsp_rdata}, {31'd0, e});
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int w;
    int stalls;
    int p0;
    int acc;

    drive(1, 1'b0, 1'b0, 12'd0, 4'd0, 32'd0);
    drive(2, 1'b0, 1'b0, 12'd0, 4'd0, 32'd0);
    if1.rsp_ready = 1'b1;
    if2.rsp_ready = 1'b1;

    // Reset values appear without a clock edge.
    #1 resetn = 1'b0;
    #1;
    chk("reset1_state", {29'd0, if1.req_ready, if1.rsp_valid, if1.rsp_err, if1.rsp_rdata},
        {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});
    chk("reset2_state", {29'd0, if2.req_ready, if2.rsp_valid, if2.rsp_err, if2.rsp_rdata},
        {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});
    @(posedge clk);
    @(posedge clk);
    #3 resetn = 1'b1;
    @(posedge clk);
    #1;

    // Full write then read, latency 1.
    issue(1, 1'b1, 12'd5, 4'hF, 32'hDEADBEEF, 32'd0, 1'b0, w);
    issue(1, 1'b0, 12'd5, 4'h0, 32'd0, 32'hDEADBEEF, 1'b0, w);
    @(negedge clk);
    chk("lat1_valid", 64'(if1.rsp_valid), 64'd1);
    @(posedge clk);
    #1;

    // Partial write: only byte 1 changes.
    issue(1, 1'b1, 12'd5, 4'h2, 32'h0000AA00, 32'd0, 1'b0, w);
    issue(1, 1'b0, 12'd5, 4'h0, 32'd0, 32'hDEADAAEF, 1'b0, w);

    // Out of range on DEPTH=3000; 952 is 3000 with bit 11 cleared.
    issue(1, 1'b1, 12'd952,  4'hF, 32'h11112222, 32'd0, 1'b0, w);
    issue(1, 1'b1, 12'd2999, 4'hF, 32'h33334444, 32'd0, 1'b0, w);
    issue(1, 1'b1, 12'd3000, 4'hF, 32'hBAD0BAD0, 32'd0, 1'b0, w);
    issue(1, 1'b0, 12'd952,  4'h0, 32'd0, 32'h11112222, 1'b0, w);
    issue(1, 1'b0, 12'd2999, 4'h0, 32'd0, 32'h33334444, 1'b0, w);
    issue(1, 1'b0, 12'd3000, 4'h0, 32'd0, 32'h00000000, 1'b1, w);
    issue(1, 1'b0, 12'd4095, 4'h0, 32'd0, 32'h00000000, 1'b1, w);

    // Streaming: 16 back-to-back reads with rsp_ready held high.
    for (int a = 16; a < 32; a++) begin
      issue(1, 1'b1, 12'(a), 4'hF, 32'hC0DE0000 | 32'(a), 32'd0, 1'b0, w);
    end
    p0     = pops1;
    stalls = 0;
    for (int a = 16; a < 32; a++) begin
      issue(1, 1'b0, 12'(a), 4'h0, 32'd0, 32'hC0DE0000 | 32'(a), 1'b0, w);
      stalls += w;
    end
    chk("stream_stalls", 64'(stalls), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("stream_pops", 64'(pops1 - p0), 64'd16);

    // Latency 2 on dut2.
    issue(2, 1'b1, 12'd7, 4'hF, 32'h01234567, 32'd0, 1'b0, w);
    issue(2, 1'b0, 12'd7, 4'h0, 32'd0, 32'h01234567, 1'b0, w);
    @(negedge clk);
    chk("lat2_not_yet", 64'(if2.rsp_valid), 64'd0);
    @(negedge clk);
    chk("lat2_valid", 64'(if2.rsp_valid), 64'd1);
    @(posedge clk);
    #1;

    // Back-pressure on dut2: three credits, then stall.
    for (int k = 0; k < 4; k++) begin
      issue(2, 1'b1, 12'(k), 4'hF, 32'hB0B00000 | 32'(k), 32'd0, 1'b0, w);
    end
    drain();
    if2.rsp_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      drive(2, 1'b1, 1'b0, 12'(k), 4'h0, 32'd0);
      @(negedge clk);
      if (!if2.req_ready) break;
      @(posedge clk);
      push_exp(2, {1'b0, 32'hB0B00000 | 32'(k)});
      $display("req  dut2 RD addr=%0d (held rsp_ready=0)", k);
      acc++;
      #1;
    end
    chk("bp_accepted", 64'(acc), 64'd3);
    chk("bp_ready_low", 64'(if2.req_ready), 64'd0);
    repeat (2) @(negedge clk);
    chk("bp_hold", {30'd0, if2.rsp_valid, if2.req_ready, if2.rsp_rdata},
        {30'd0, 1'b1, 1'b0, 32'hB0B00000});
    @(posedge clk);
    #1 if2.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_in_pop_cycle", 64'(if2.req_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("bp_ready_after_pop", 64'(if2.req_ready), 64'd1);
    @(posedge clk);
    push_exp(2, {1'b0, 32'hB0B00003});
    $display("req  dut2 RD addr=3 (after release)");
    #1;
    drive(2, 1'b0, 1'b0, 12'd0, 4'd0, 32'd0);
    drain();

    // Reset with two responses buffered in dut1.
    if1.rsp_ready = 1'b0;
    issue(1, 1'b0, 12'd16, 4'h0, 32'd0, 32'hC0DE0010, 1'b0, w);
    issue(1, 1'b0, 12'd17, 4'h0, 32'd0, 32'hC0DE0011, 1'b0, w);
    @(negedge clk);
    chk("rst_pre_full", {62'd0, if1.rsp_valid, if1.req_ready}, {62'd0, 1'b1, 1'b0});
    #2 resetn = 1'b0;
    #1;
    chk("rst_mid_state", {29'd0, if1.req_ready, if1.rsp_valid, if1.rsp_err, if1.rsp_rdata},
        {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});
    q1.delete();
    q2.delete();
    #4 resetn = 1'b1;
    if1.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    issue(1, 1'b0, 12'd5, 4'h0, 32'd0, 32'hDEADAAEF, 1'b0, w);
    issue(2, 1'b0, 12'd7, 4'h0, 32'd0, 32'h01234567, 1'b0, w);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/d_ram_bank.md
# d_ram_bank

Parametrised single-port data RAM bank with a valid/ready request/response interface, byte-strobe writes and a configurable read latency of 1 or 2 cycles. Read data goes into an internal response buffer, so the requester can back-pressure responses without losing data. The bank sits between the load/store unit (or a bus slave adapter) and the data memory. It supersedes the fixed 32-bit, combinational-read, whole-word-write data RAM.

## Interface
Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 12, word-address width.
- DEPTH, 4096, number of words; must be ≤ 2^ADDR_W.
- RD_LAT, 1, read latency in cycles; legal values are 1 or 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  bank can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wstrb  in  DATA_W/8  byte write enables; bit i covers bits [8i+7:8i].
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  DATA_W  read data.
- rsp_err  out  1  read address was ≥ DEPTH.

## Operation
- A request is accepted on a rising edge where req_valid and req_ready are both 1.
- Accepted write:
  - Each byte with req_wstrb[i]=1 is updated at that edge; other bytes are unchanged.
  - If req_addr ≥ DEPTH, the write is dropped silently.
  - A write produces no response.
- Accepted read:
  - The array word is sampled at the accept edge.
  - The data passes through RD_LAT−1 extra pipeline registers.
  - It is then pushed into a response FIFO of depth RD_LAT+1.
  - If req_addr ≥ DEPTH, rdata = 0 and err = 1.
- Single port: at most one read or write per cycle. A read accepted on the edge after a write to the same address returns the new data.
- Response FIFO:
  - rsp_valid = FIFO non-empty.
  - rsp_rdata and rsp_err show the FIFO head.
  - The head pops on an edge where rsp_valid and rsp_ready are both 1.
- Credit counter cnt, range 0..RD_LAT+1:
  - Counts reads that are accepted but not yet popped.
  - +1 on read accept, −1 on pop; both on the same edge leaves it unchanged.
  - Writes do not change cnt.
- req_ready = (cnt < RD_LAT+1).
  - It depends only on registered state: no combinational path from req_valid, req_we or rsp_ready.
  - It applies to writes as well as reads.
- Responses are returned in request order. The FIFO can never overflow, because credits bound it.
- Reset:
  - Clears cnt, the pipeline valid bits and the FIFO pointers.
  - Memory contents are not reset.
  - Reads that are in flight or buffered at reset are discarded.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. Outputs take these values immediately when resetn falls, independent of clk.
- Read latency from the accept edge E to rsp_valid=1:
  - RD_LAT=1: after edge E (visible in cycle E+1).
  - RD_LAT=2: after edge E+1.
- With rsp_ready held at 1, the bank sustains one read per cycle; cnt settles at RD_LAT.
- With rsp_ready held at 0:
  - Exactly RD_LAT+1 reads are accepted, then req_ready=0.
  - Once rsp_ready=1, req_ready returns to 1 one edge after the first pop.
- While cnt = RD_LAT+1, req_ready stays 0 in the same cycle as a pop. The credit frees at the pop edge.
- When not popped, rsp_rdata and rsp_err are stable for as long as rsp_valid=1.

## Test plan
- Reset, then write 0xDEADBEEF to addr 5 with wstrb=0xF, then read addr 5 → RD_LAT=1: rsp_valid high one cycle after the read accept, rdata=0xDEADBEEF, err=0.
- Partial write: write wstrb=0x2 with wdata=0x0000AA00 to addr 5 → a following read returns 0xDEADAAEF.
- Back-pressure, RD_LAT=2:
  - Hold rsp_ready=0 and issue reads to addrs 0..3 back to back → exactly 3 accepted, req_ready=0.
  - Release rsp_ready → responses come out in order 0,1,2; the 4th read is then accepted.
- Streaming: RD_LAT=1, rsp_ready=1, 16 consecutive reads → req_ready stays 1 throughout, one response per cycle in order.
- Out of range, DEPTH=3000:
  - Write addr 3000 → no array change.
  - Read addr 3000 → rdata=0, err=1.
- Reset mid-operation: assert resetn=0 asynchronously with 2 responses buffered → rsp_valid=0 and req_ready=1 immediately. After release, memory still holds the previously written data.
